stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 141 ++++++++++++++
 tb/tb_stream_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// Packs Ratio input words of DataWidth bits into one wide output beat.
// Define STREAM_PACKER_TIMEOUT_EN to flush partial beats after TimeoutCycles idle cycles.
module stream_packer_lane #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntW      = 2,
    parameter int unsigned Lane      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CntW-1:0]      cnt,
    input  logic                 accept,
    input  logic                 close,
    input  logic                 flush,
    input  logic [DataWidth-1:0] in_data,
    output logic [DataWidth-1:0] lane_data,
    output logic                 lane_keep
);
    localparam logic [CntW-1:0] LaneIdx = CntW'(Lane);

    logic [DataWidth-1:0] acc;
    logic                 hit;
    logic                 below;

    assign hit   = (cnt == LaneIdx);
    assign below = (LaneIdx < cnt);

    // Lanes above the fill point are zeroed on load, so acc never needs clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            lane_data <= '0;
            lane_keep <= 1'b0;
        end else begin
            if (accept && hit)
                acc <= in_data;
            if (close) begin
                lane_data <= below ? acc : (hit ? in_data : '0);
                lane_keep <= below || hit;
            end else if (flush) begin
                lane_data <= below ? acc : '0;
                lane_keep <= below;
            end
        end
    end
endmodule

module stream_packer #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned Ratio         = 4,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DataWidth-1:0]       in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [Ratio*DataWidth-1:0] out_data,
    output logic [Ratio-1:0]           out_keep,
    output logic                       out_last,
    input  logic                       out_ready
);
    localparam int unsigned CntW = $clog2(Ratio);

    if (Ratio < 2 || (Ratio & (Ratio - 1)) != 0) begin : g_bad_ratio
        $error("stream_packer: Ratio must be a power of two >= 2");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("stream_packer: TimeoutCycles must be >= 1");
    end

    logic [CntW-1:0] cnt;
    logic            accept;
    logic            close;
    logic            flush;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign close    = accept && (in_last || cnt == CntW'(Ratio - 1));

`ifdef STREAM_PACKER_TIMEOUT_EN
    localparam int unsigned     IdleW   = $clog2(TimeoutCycles + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TimeoutCycles);

    logic [IdleW-1:0] idle;

    // An accepted word always wins over the flush in the same cycle.
    assign flush = (idle == IdleMax) && (cnt != '0) && in_ready && !accept;

    always_ff @(posedge clk) begin
        if (reset)
            idle <= '0;
        else if (accept || flush)
            idle <= '0;
        else if (cnt != '0 && idle != IdleMax)
            idle <= idle + 1'b1;
    end
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (close) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            out_last  <= in_last;
        end else if (flush) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
        end else begin
            if (accept)
                cnt <= cnt + 1'b1;
            if (out_ready)
                out_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < Ratio; k++) begin : g_lane
        stream_packer_lane #(
            .DataWidth(DataWidth),
            .CntW     (CntW),
            .Lane     (k)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .cnt      (cnt),
            .accept   (accept),
            .close    (close),
            .flush    (flush),
            .in_data  (in_data),
            .lane_data(out_data[k*DataWidth +: DataWidth]),
            .lane_keep(out_keep[k])
        );
    end
endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer: stimulus pushes expected beats, a monitor pops and compares.
module tb_stream_packer;
    localparam int DW = 32;
    localparam int R  = 4;
    localparam int TO = 16;
    localparam int W  = R * DW;

    typedef struct packed {
        logic [W-1:0] data;
        logic [R-1:0] keep;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [R-1:0]  out_keep;
    logic          out_last;
    logic          out_ready;

    beat_t exp_q[$];
    int    beat_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    stalls = 0;

    stream_packer #(.DataWidth(DW), .Ratio(R), .TimeoutCycles(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack4(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic expect_beat(input logic [W-1:0] d, input logic [R-1:0] k, input logic l);
        beat_t e;
        e.data = d; e.keep = k; e.last = l;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 0) stalls++;
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: word %0h never accepted, got in_ready 0 expected 1", d);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: a beat is consumed on the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got data %0h keep %b last %b expected none",
                         out_data, out_keep, out_last);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", out_data, e.data);
                chk("beat_keep", W'(out_keep), W'(e.keep));
                chk("beat_last", W'(out_last), W'(e.last));
            end
            beat_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int acc_cyc;
        int lat;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_keep", W'(out_keep), W'(0));
        chk("rst_out_last", W'(out_last), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;

        // Full beat
        expect_beat(pack4(32'h11, 32'h22, 32'h33, 32'h44), 4'b1111, 1'b0);
        send(32'h11, 0); send(32'h22, 0); send(32'h33, 0); send(32'h44, 0);

        // Short packet
        expect_beat(pack4(32'hA, 32'hB, 32'h0, 32'h0), 4'b0011, 1'b1);
        send(32'hA, 0); send(32'hB, 1);
        repeat (2) @(posedge clk); #1;

        // Single-lane last beats back to back: no bubble, one-edge latency
        for (int i = 1; i <= 3; i++)
            expect_beat(pack4(DW'(i), 32'h0, 32'h0, 32'h0), 4'b0001, 1'b1);
        n0 = beat_cyc.size();
        send(32'h1, 1);
        chk("latency_valid", W'(out_valid), W'(1));
        send(32'h2, 1); send(32'h3, 1);
        repeat (3) @(posedge clk); #1;
        chk("nobubble_gap1", W'(beat_cyc[n0+1] - beat_cyc[n0]), W'(1));
        chk("nobubble_gap2", W'(beat_cyc[n0+2] - beat_cyc[n0+1]), W'(1));

        // Backpressure hold
        out_ready = 1'b0;
        expect_beat(pack4(32'hC1, 32'hC2, 32'hC3, 32'hC4), 4'b1111, 1'b0);
        send(32'hC1, 0); send(32'hC2, 0); send(32'hC3, 0); send(32'hC4, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", W'(in_ready), W'(0));
            chk("stall_out_valid", W'(out_valid), W'(1));
            chk("stall_out_data", out_data, pack4(32'hC1, 32'hC2, 32'hC3, 32'hC4));
            chk("stall_out_keep", W'(out_keep), W'(4'b1111));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;

        // Sustained throughput
        stalls = 0;
        n0 = beat_cyc.size();
        for (int g = 0; g < 4; g++)
            expect_beat(pack4(DW'(256 + 4*g), DW'(257 + 4*g), DW'(258 + 4*g), DW'(259 + 4*g)),
                        4'b1111, 1'b0);
        for (int i = 0; i < 16; i++) send(DW'(256 + i), 0);
        repeat (3) @(posedge clk); #1;
        chk("tput_stalls", W'(stalls), W'(0));
        chk("tput_beats", W'(beat_cyc.size() - n0), W'(4));
        for (int i = 1; i < 4; i++)
            chk("tput_gap", W'(beat_cyc[n0+i] - beat_cyc[n0+i-1]), W'(4));

        // Reset mid-accumulation discards the partial beat
        send(32'hE1, 0); send(32'hE2, 0);
        do_reset();
        @(negedge clk);
        chk("rst_part_in_ready", W'(in_ready), W'(1));
        chk("rst_part_out_valid", W'(out_valid), W'(0));
        @(posedge clk); #1;
        expect_beat(pack4(32'hF1, 32'hF2, 32'hF3, 32'hF4), 4'b1111, 1'b0);
        send(32'hF1, 0); send(32'hF2, 0); send(32'hF3, 0); send(32'hF4, 0);
        repeat (2) @(posedge clk); #1;

        // Reset with a pending beat discards it
        out_ready = 1'b0;
        send(32'hD1, 0); send(32'hD2, 1);
        do_reset();
        @(negedge clk);
        chk("rst_pend_out_valid", W'(out_valid), W'(0));
        chk("rst_pend_out_keep", W'(out_keep), W'(0));
        chk("rst_pend_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        expect_beat(pack4(32'h77, 32'h0, 32'h0, 32'h0), 4'b0001, 1'b1);
        send(32'h77, 1);
        repeat (2) @(posedge clk); #1;

        // Idle partial beat: flushed only when the timeout feature is built in
        n0 = beat_cyc.size();
`ifdef STREAM_PACKER_TIMEOUT_EN
        expect_beat(pack4(32'h5, 32'h0, 32'h0, 32'h0), 4'b0001, 1'b0);
`endif
        send(32'h5, 0);
        acc_cyc = cyc;
        repeat (40) @(posedge clk); #1;
`ifdef STREAM_PACKER_TIMEOUT_EN
        chk("timeout_beats", W'(beat_cyc.size() - n0), W'(1));
        if (beat_cyc.size() > n0) begin
            // 16 idle cycles, counted either from the accept edge or the first idle edge
            lat = beat_cyc[n0] - acc_cyc;
            checks++;
            if (lat < TO || lat > TO + 1) begin
                errors++;
                $display("FAIL timeout_latency: got %0d expected %0d..%0d", lat, TO, TO + 1);
            end
        end
`else
        chk("no_timeout_beat", W'(beat_cyc.size() - n0), W'(0));
        chk("no_timeout_valid", W'(out_valid), W'(0));
`endif

        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
